mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage; sits directly downstream of ex_stage, fed by the EX/MEM register.
- Performs RV32I loads and stores over a req/ready data-memory interface, and stalls the pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register.
- Its registered result returns to ex_stage as the mem_wb_result forwarding source.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles a request may wait for dmem_ready before an access fault (must be >=1).
- TMO_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  EX/MEM slot holds a live instruction
- ex_alu_result  in  32  address for loads/stores; pass-through result otherwise
- ex_rs2_data  in  32  store data (already forwarded)
- ex_mem_read  in  1  load instruction
- ex_mem_write  in  1  store instruction
- ex_funct3  in  3  access size/sign (RV32I load/store funct3)
- ex_rd  in  5  destination register
- ex_reg_write  in  1  writes back
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  store data, lane-shifted
- dmem_rdata  in  32  read data, valid when dmem_ready
- dmem_ready  in  1  access completes this cycle
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- mem_wb_valid  out  1  MEM/WB register valid
- mem_wb_result  out  32  load data or ALU result
- mem_wb_rd  out  5  destination
- mem_wb_reg_write  out  1  write-enable (already qualified by valid)
- mem_fault  out  1  one-cycle pulse: timeout or misaligned access
- mem_fault_addr  out  32  faulting ex_alu_result, held until next fault

Behaviour:
- Reset: all outputs 0. state=IDLE, tmo_cnt=0.
- memop = ex_valid & (ex_mem_read | ex_mem_write). Both read and write set is illegal; treat as a load.

Non-memop instruction:
- No stall.
- Next edge: mem_wb_result <= ex_alu_result; rd/reg_write/valid copied.

dmem_req (combinational):
- dmem_req = memop & ~misalign_block & (state==IDLE | state==WAIT).
- addr, be, wdata and we are derived combinationally from ex_* inputs.
- The ex_* inputs are held stable by mem_stall, so the request is stable until ready.

mem_stall = dmem_req & ~dmem_ready. A zero-wait access (ready in the same cycle as req) does not stall.

FSM:
- IDLE -> WAIT: dmem_req & ~dmem_ready; tmo_cnt <= 1.
- WAIT -> WAIT: ~dmem_ready & tmo_cnt < TIMEOUT_CYCLES; tmo_cnt increments.
- WAIT -> IDLE on dmem_ready: completion.
- WAIT -> IDLE on timeout (tmo_cnt==TIMEOUT_CYCLES & ~dmem_ready):
  - mem_fault pulses; mem_wb_valid <= 0 (instruction squashed); stall drops that cycle.
  - dmem_req is forced 0 in that cycle.
- dmem_ready arriving in the timeout cycle wins: completion, no fault.

Completion edge:
- MEM/WB captures the result.
- Loads: select lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the whole word.
- Stores: mem_wb_reg_write <= 0 regardless of ex_reg_write.

Store lanes:
- SB: be = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
- SH: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{rs2[15:0]}}.
- SW: be = 4'b1111.

Other rules:
- dmem_ready outside a request is ignored.
- Reset mid-WAIT returns to IDLE next edge; the bus slave must tolerate an abandoned request.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: halfword with addr[0]=1, or word with addr[1:0]!=0, sets misalign_block.
  - No request, no stall.
  - mem_fault pulses, with mem_fault_addr=ex_alu_result, on the edge of that instruction's slot.
  - mem_wb_valid <= 0.
- Undefined: misalign_block=0; low address bits are ignored for lane selection beyond the access size (access forced aligned); never faults on alignment.

Decomposition:
- Shared riscv_pkg: funct3 encodings (F3_LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010) and the FSM state encoding (IDLE=0, WAIT=1).
- One sub-module, load_extract: combinational lane select plus sign/zero extension from (rdata, addr[1:0], funct3).

Test Plan:
- ALU pass-through: ex_alu_result=0x1234, no memop, rd=5 -> next cycle mem_wb_result=0x1234, rd=5, reg_write=1, mem_stall=0 throughout.
- LB zero-wait: addr=0x103, funct3=000, rdata=0x80FF_FF00, ready same cycle -> dmem_addr=0x100, no stall, mem_wb_result=0xFFFFFF80.
- SH with 3 wait states: addr=0x202, rs2=0xABCD1234 -> be=1100, wdata=0x12341234, mem_stall high 3 cycles, req stable, mem_wb_reg_write=0.
- Timeout: TIMEOUT_CYCLES=4, LW, ready never asserted -> stall for 4 cycles, then mem_fault pulse, mem_fault_addr=addr, mem_wb_valid=0, state IDLE.
- Misaligned LW addr=0x101:
  - MISALIGN_TRAP_EN defined -> no dmem_req, mem_fault=1.
  - Undefined -> dmem_addr=0x100, normal completion.
- Reset during WAIT: assert rst mid-stall -> next cycle all outputs 0, state IDLE, then a fresh LBU addr=0x3 with rdata=0x7F000000 returns 0x0000007F.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the pipeline stages.
// funct3 load/store codes and the MEM stage FSM states.
package riscv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ready bus between the MEM stage and memory.
// master = MEM stage, slave = memory / bus bridge.
interface mem_stage_if;
   import riscv_pkg::*;

   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_rdata, dmem_ready
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_rdata, dmem_ready
   );

endinterface

// File: rtl/mem_stage_load_extract.sv
// Load lane select and sign/zero extension.
// Halfword lane uses addr[1] only, so odd halfwords read aligned.
module load_extract
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] byte_sh;
   logic [31:0] half_sh;
   logic [7:0]  b;
   logic [15:0] h;

   assign byte_sh = rdata >> {addr, 3'b000};
   assign half_sh = rdata >> {addr[1], 4'b0000};
   assign b = byte_sh[7:0];
   assign h = half_sh[15:0];

   // Size/sign select; unknown codes fall back to a full word.
   always_comb begin
      data = rdata;
      case (funct3)
         F3_LB:   data = {{24{b[7]}}, b};
         F3_LH:   data = {{16{h[15]}}, h};
         F3_LW:   data = rdata;
         F3_LBU:  data = {24'h0, b};
         F3_LHU:  data = {16'h0, h};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: load/store over req/ready, stall, MEM/WB register.
// Optional MISALIGN_TRAP_EN turns misaligned LH/LW/SH/SW into faults.
module mem_stage
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TMO_W          = 5
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_rs2_data,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [2:0]  ex_funct3,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   mem_stage_if.master dmem,
   output logic        mem_stall,
   output logic        mem_wb_valid,
   output logic [31:0] mem_wb_result,
   output logic [4:0]  mem_wb_rd,
   output logic        mem_wb_reg_write,
   output logic        mem_fault,
   output logic [31:0] mem_fault_addr
);

   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

   logic [0:0]       state;
   logic [TMO_W-1:0] tmo_cnt;
   logic             memop;
   logic             is_load;
   logic             is_store;
   logic             misalign_block;
   logic             timeout;
   logic             req;
   logic             fault_now;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic [31:0]      load_data;

   assign memop    = ex_valid & (ex_mem_read | ex_mem_write);
   assign is_load  = memop & ex_mem_read;
   assign is_store = memop & ~ex_mem_read;

`ifdef MISALIGN_TRAP_EN
   assign misalign_block = memop &
      (((ex_funct3[1:0] == 2'b01) & ex_alu_result[0]) |
       ((ex_funct3[1:0] == 2'b10) & (|ex_alu_result[1:0])));
`else
   assign misalign_block = 1'b0;
`endif

   assign timeout = (state == ST_WAIT) & (tmo_cnt == TMO_MAX) &
                    ~dmem.dmem_ready;
   assign req       = ~rst & memop & ~misalign_block & ~timeout;
   assign mem_stall = req & ~dmem.dmem_ready;
   assign fault_now = timeout | misalign_block;

   // Byte enables and lane-replicated store data by access size.
   always_comb begin
      be    = 4'b1111;
      wdata = ex_rs2_data;
      case (ex_funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << ex_alu_result[1:0];
            wdata = {4{ex_rs2_data[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << {ex_alu_result[1], 1'b0};
            wdata = {2{ex_rs2_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = ex_rs2_data;
         end
      endcase
   end

   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = req & is_store;
   assign dmem.dmem_addr  = req ? {ex_alu_result[31:2], 2'b00} : 32'h0;
   assign dmem.dmem_be    = req ? be : 4'h0;
   assign dmem.dmem_wdata = req ? wdata : 32'h0;

   load_extract u_load_extract (
      .rdata  (dmem.dmem_rdata),
      .addr   (ex_alu_result[1:0]),
      .funct3 (ex_funct3),
      .data   (load_data)
   );

   // Wait-state tracking; a request abandoned on timeout returns to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         tmo_cnt <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (mem_stall) begin
                  state   <= ST_WAIT;
                  tmo_cnt <= TMO_W'(1);
               end
            end
            ST_WAIT: begin
               if (dmem.dmem_ready | timeout) begin
                  state   <= ST_IDLE;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               tmo_cnt <= '0;
            end
         endcase
      end
   end

   // MEM/WB register: held while stalled, squashed on a fault.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_wb_valid     <= 1'b0;
         mem_wb_result    <= 32'h0;
         mem_wb_rd        <= 5'h0;
         mem_wb_reg_write <= 1'b0;
         mem_fault        <= 1'b0;
         mem_fault_addr   <= 32'h0;
      end else begin
         mem_fault <= fault_now;
         if (fault_now) begin
            mem_fault_addr   <= ex_alu_result;
            mem_wb_valid     <= 1'b0;
            mem_wb_reg_write <= 1'b0;
         end else if (!mem_stall) begin
            mem_wb_valid     <= ex_valid;
            mem_wb_rd        <= ex_rd;
            mem_wb_reg_write <= ex_valid & ex_reg_write & ~is_store;
            mem_wb_result    <= is_load ? load_data : ex_alu_result;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a hand-driven memory slave.
// Build with +define+MISALIGN_TRAP_EN to check the trap variant.
module tb_mem_stage;
   import riscv_pkg::*;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_rs2_data;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        mem_stall;
   logic        mem_wb_valid;
   logic [31:0] mem_wb_result;
   logic [4:0]  mem_wb_rd;
   logic        mem_wb_reg_write;
   logic        mem_fault;
   logic [31:0] mem_fault_addr;

   int n_cmp = 0;
   int n_err = 0;

   mem_stage_if dmem ();

   mem_stage #(.TIMEOUT_CYCLES(4), .TMO_W(5)) dut (
      .clk              (clk),
      .rst              (rst),
      .ex_valid         (ex_valid),
      .ex_alu_result    (ex_alu_result),
      .ex_rs2_data      (ex_rs2_data),
      .ex_mem_read      (ex_mem_read),
      .ex_mem_write     (ex_mem_write),
      .ex_funct3        (ex_funct3),
      .ex_rd            (ex_rd),
      .ex_reg_write     (ex_reg_write),
      .dmem             (dmem),
      .mem_stall        (mem_stall),
      .mem_wb_valid     (mem_wb_valid),
      .mem_wb_result    (mem_wb_result),
      .mem_wb_rd        (mem_wb_rd),
      .mem_wb_reg_write (mem_wb_reg_write),
      .mem_fault        (mem_fault),
      .mem_fault_addr   (mem_fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      ex_valid = 0; ex_alu_result = 0; ex_rs2_data = 0;
      ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0;
      ex_rd = 0; ex_reg_write = 0;
      dmem.dmem_rdata = 0; dmem.dmem_ready = 0;
   endtask

   task automatic op(input logic rd_en, input logic wr_en,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic [4:0] r);
      ex_valid = 1; ex_mem_read = rd_en; ex_mem_write = wr_en;
      ex_funct3 = f3; ex_alu_result = a; ex_rs2_data = d;
      ex_rd = r; ex_reg_write = 1;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1; idle();
      step(); step();
      @(negedge clk);
      n_cmp++; if ({mem_wb_valid, mem_wb_reg_write, mem_fault, mem_stall} !== 4'b0) begin
         n_err++; $display("FAIL reset_flags got=%b exp=0000",
            {mem_wb_valid, mem_wb_reg_write, mem_fault, mem_stall}); end
      n_cmp++; if ({mem_wb_result, mem_fault_addr, mem_wb_rd} !== 69'h0) begin
         n_err++; $display("FAIL reset_data got=%h %h %h exp=0",
            mem_wb_result, mem_fault_addr, mem_wb_rd); end
      n_cmp++; if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_be} !== 6'h0) begin
         n_err++; $display("FAIL reset_bus got=%b exp=0",
            {dmem.dmem_req, dmem.dmem_we, dmem.dmem_be}); end
      n_cmp++; if (dut.state !== ST_IDLE || dut.tmo_cnt !== 5'd0) begin
         n_err++; $display("FAIL reset_fsm got=%b/%0d exp=0/0", dut.state, dut.tmo_cnt); end
      @(posedge clk); #1 rst = 0;
   endtask

   task automatic test_passthrough();
      op(0, 0, 3'b000, 32'h1234, 32'h0, 5'd5);
      dmem.dmem_ready = 1;
      @(negedge clk);
      n_cmp++; if (mem_stall !== 1'b0 || dmem.dmem_req !== 1'b0) begin
         n_err++; $display("FAIL pass_stall got=%b%b exp=00", mem_stall, dmem.dmem_req); end
      step();
      n_cmp++; if (mem_wb_result !== 32'h1234 || mem_wb_rd !== 5'd5) begin
         n_err++; $display("FAIL pass_result got=%h/%0d exp=1234/5", mem_wb_result, mem_wb_rd); end
      n_cmp++; if (mem_wb_reg_write !== 1'b1 || mem_wb_valid !== 1'b1 || mem_fault !== 1'b0) begin
         n_err++; $display("FAIL pass_flags got=%b%b%b exp=110",
            mem_wb_reg_write, mem_wb_valid, mem_fault); end
      idle();
   endtask

   task automatic test_lb_zero_wait();
      op(1, 0, F3_LB, 32'h103, 32'h0, 5'd7);
      dmem.dmem_rdata = 32'h80FF_FF00; dmem.dmem_ready = 1;
      @(negedge clk);
      n_cmp++; if (dmem.dmem_req !== 1'b1 || dmem.dmem_addr !== 32'h100 || dmem.dmem_we !== 1'b0) begin
         n_err++; $display("FAIL lb_bus got=%b %h %b exp=1 00000100 0",
            dmem.dmem_req, dmem.dmem_addr, dmem.dmem_we); end
      n_cmp++; if (mem_stall !== 1'b0) begin
         n_err++; $display("FAIL lb_stall got=%b exp=0", mem_stall); end
      step();
      n_cmp++; if (mem_wb_result !== 32'hFFFF_FF80 || mem_wb_reg_write !== 1'b1) begin
         n_err++; $display("FAIL lb_result got=%h/%b exp=ffffff80/1", mem_wb_result, mem_wb_reg_write); end
      idle();
   endtask

   task automatic test_sh_wait();
      op(0, 1, F3_SH, 32'h202, 32'hABCD_1234, 5'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (mem_stall !== 1'b1 || dmem.dmem_req !== 1'b1 || dmem.dmem_we !== 1'b1) begin
            n_err++; $display("FAIL sh_stall%0d got=%b%b%b exp=111", i,
               mem_stall, dmem.dmem_req, dmem.dmem_we); end
         n_cmp++; if (dmem.dmem_be !== 4'b1100 || dmem.dmem_wdata !== 32'h1234_1234 ||
                      dmem.dmem_addr !== 32'h200) begin
            n_err++; $display("FAIL sh_lanes%0d got=%b %h %h exp=1100 12341234 00000200", i,
               dmem.dmem_be, dmem.dmem_wdata, dmem.dmem_addr); end
         step();
      end
      dmem.dmem_ready = 1;
      @(negedge clk);
      n_cmp++; if (mem_stall !== 1'b0) begin
         n_err++; $display("FAIL sh_release got=%b exp=0", mem_stall); end
      step();
      n_cmp++; if (mem_wb_reg_write !== 1'b0 || mem_wb_valid !== 1'b1 || mem_fault !== 1'b0) begin
         n_err++; $display("FAIL sh_wb got=%b%b%b exp=010",
            mem_wb_reg_write, mem_wb_valid, mem_fault); end
      idle();
   endtask

   task automatic test_timeout();
      op(1, 0, F3_LW, 32'h400, 32'h0, 5'd9);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++; if (mem_stall !== 1'b1) begin
            n_err++; $display("FAIL tmo_stall%0d got=%b exp=1", i, mem_stall); end
         step();
      end
      @(negedge clk);
      n_cmp++; if (mem_stall !== 1'b0 || dmem.dmem_req !== 1'b0) begin
         n_err++; $display("FAIL tmo_drop got=%b%b exp=00", mem_stall, dmem.dmem_req); end
      step();
      n_cmp++; if (mem_fault !== 1'b1 || mem_fault_addr !== 32'h400) begin
         n_err++; $display("FAIL tmo_fault got=%b %h exp=1 00000400", mem_fault, mem_fault_addr); end
      n_cmp++; if (mem_wb_valid !== 1'b0 || mem_wb_reg_write !== 1'b0 || dut.state !== ST_IDLE) begin
         n_err++; $display("FAIL tmo_squash got=%b%b%b exp=000",
            mem_wb_valid, mem_wb_reg_write, dut.state); end
      idle();
      step();
      n_cmp++; if (mem_fault !== 1'b0 || mem_fault_addr !== 32'h400) begin
         n_err++; $display("FAIL tmo_pulse got=%b %h exp=0 00000400", mem_fault, mem_fault_addr); end
   endtask

   task automatic test_ready_at_timeout();
      op(1, 0, F3_LW, 32'h600, 32'h0, 5'd10);
      for (int i = 0; i < 4; i++) step();
      dmem.dmem_rdata = 32'h1234_5678; dmem.dmem_ready = 1;
      @(negedge clk);
      n_cmp++; if (dmem.dmem_req !== 1'b1 || mem_stall !== 1'b0) begin
         n_err++; $display("FAIL race_bus got=%b%b exp=10", dmem.dmem_req, mem_stall); end
      step();
      n_cmp++; if (mem_fault !== 1'b0 || mem_wb_valid !== 1'b1 || mem_wb_result !== 32'h1234_5678) begin
         n_err++; $display("FAIL race_done got=%b%b %h exp=01 12345678",
            mem_fault, mem_wb_valid, mem_wb_result); end
      idle();
   endtask

   task automatic test_misalign();
      op(1, 0, F3_LW, 32'h101, 32'h0, 5'd11);
      dmem.dmem_rdata = 32'hDEAD_BEEF; dmem.dmem_ready = 1;
      @(negedge clk);
`ifdef MISALIGN_TRAP_EN
      n_cmp++; if (dmem.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
         n_err++; $display("FAIL mis_noreq got=%b%b exp=00", dmem.dmem_req, mem_stall); end
      step();
      n_cmp++; if (mem_fault !== 1'b1 || mem_fault_addr !== 32'h101 || mem_wb_valid !== 1'b0) begin
         n_err++; $display("FAIL mis_fault got=%b %h %b exp=1 00000101 0",
            mem_fault, mem_fault_addr, mem_wb_valid); end
`else
      n_cmp++; if (dmem.dmem_req !== 1'b1 || dmem.dmem_addr !== 32'h100) begin
         n_err++; $display("FAIL mis_req got=%b %h exp=1 00000100", dmem.dmem_req, dmem.dmem_addr); end
      step();
      n_cmp++; if (mem_fault !== 1'b0 || mem_wb_result !== 32'hDEAD_BEEF || mem_fault_addr !== 32'h400) begin
         n_err++; $display("FAIL mis_done got=%b %h %h exp=0 deadbeef 00000400",
            mem_fault, mem_wb_result, mem_fault_addr); end
`endif
      idle();
   endtask

   task automatic test_back_to_back();
      op(1, 0, F3_LHU, 32'h102, 32'h0, 5'd12);
      dmem.dmem_rdata = 32'h8001_0000; dmem.dmem_ready = 1;
      step();
      n_cmp++; if (mem_wb_result !== 32'h0000_8001) begin
         n_err++; $display("FAIL b2b_lhu got=%h exp=00008001", mem_wb_result); end
      op(1, 0, F3_LH, 32'h102, 32'h0, 5'd13);
      step();
      n_cmp++; if (mem_wb_result !== 32'hFFFF_8001 || mem_wb_rd !== 5'd13) begin
         n_err++; $display("FAIL b2b_lh got=%h/%0d exp=ffff8001/13", mem_wb_result, mem_wb_rd); end
      op(0, 1, F3_SB, 32'h001, 32'h0000_0055, 5'd14);
      @(negedge clk);
      n_cmp++; if (dmem.dmem_be !== 4'b0010 || dmem.dmem_wdata !== 32'h5555_5555) begin
         n_err++; $display("FAIL b2b_sb got=%b %h exp=0010 55555555", dmem.dmem_be, dmem.dmem_wdata); end
      step();
      n_cmp++; if (mem_wb_reg_write !== 1'b0 || mem_wb_valid !== 1'b1) begin
         n_err++; $display("FAIL b2b_sbwb got=%b%b exp=01", mem_wb_reg_write, mem_wb_valid); end
      idle();
   endtask

   task automatic test_reset_wait();
      op(1, 0, F3_LW, 32'h500, 32'h0, 5'd15);
      step(); step();
      n_cmp++; if (dut.state !== ST_WAIT || mem_stall !== 1'b1) begin
         n_err++; $display("FAIL rw_inwait got=%b%b exp=11", dut.state, mem_stall); end
      rst = 1; idle();
      step();
      n_cmp++; if (dut.state !== ST_IDLE || dut.tmo_cnt !== 5'd0 || mem_wb_valid !== 1'b0 ||
                   mem_wb_result !== 32'h0 || mem_fault_addr !== 32'h0 || dmem.dmem_req !== 1'b0) begin
         n_err++; $display("FAIL rw_reset got=%b %0d %b %h %h %b exp=0 0 0 0 0 0",
            dut.state, dut.tmo_cnt, mem_wb_valid, mem_wb_result, mem_fault_addr, dmem.dmem_req); end
      rst = 0;
      op(1, 0, F3_LBU, 32'h3, 32'h0, 5'd16);
      dmem.dmem_rdata = 32'h7F00_0000; dmem.dmem_ready = 1;
      step();
      n_cmp++; if (mem_wb_result !== 32'h0000_007F || mem_wb_valid !== 1'b1) begin
         n_err++; $display("FAIL rw_lbu got=%h/%b exp=0000007f/1", mem_wb_result, mem_wb_valid); end
      idle();
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_lb_zero_wait();
      test_sh_wait();
      test_timeout();
      test_ready_at_timeout();
      test_misalign();
      test_back_to_back();
      test_reset_wait();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
